// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-stage controller:
//   state_t     : FSM states of mem_stage_ctrl
//   offset_bits : number of byte-offset address bits inside one data word
package mem_stage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    HALTED
  } state_t;

  // log2(data_w/8): how many low address bits select a byte within a word.
  function automatic int offset_bits(input int data_w);
    int n;
    int v;
    n = 0;
    v = data_w / 8;
    while (v > 1) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// mem_align_chk
// Combinational word-alignment check for a byte address.
// Ports:
//   addr    in  ADDR_W  byte address to test
//   aligned out 1       high when the byte-offset bits of addr are all zero
module mem_align_chk
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              aligned
);

  localparam int OFF_W = offset_bits(DATA_W);

  // Masking instead of slicing keeps every address bit referenced.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  assign aligned = ((addr & OFF_MASK) == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller: turns a pipeline load/store into a memory request,
// freezes upstream stages while it is in flight, and handles halt, misaligned
// accesses and (optionally) memory timeouts with a one-cycle dump pulse.
// Optional feature macro: MEM_TIMEOUT_EN (timeout counter in WAIT).
// Ports:
//   clk, rst                        clock, async active-low reset
//   req_valid/req_write/req_addr/req_wdata   pipeline request
//   halt                            pipeline halt request
//   stall, resp_valid, rdata        pipeline-side status and load data
//   align_err, timeout_err          sticky error flags
//   createdump                      one-cycle dump pulse on entry to HALTED
//   mem_en/mem_wr/mem_addr/mem_wdata  memory request
//   mem_stall, mem_done, mem_rdata  memory handshake and read data
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              halt,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              align_err,
  output logic              timeout_err,
  output logic              createdump,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_nxt;
  logic   write_q;
  logic   halt_pend_q;
  logic   dump_q;
  logic   align_err_q;
  logic   aligned;
  logic   req_ok;
  logic   accept;
  logic   misaligned;
  logic   load_done;
  logic   timeout_hit;

  mem_align_chk #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_align (
    .addr   (req_addr),
    .aligned(aligned)
  );

  // Halt beats a simultaneous request, so a request only counts without halt.
  assign req_ok     = (state == IDLE) && req_valid && !halt;
  assign accept     = req_ok && aligned;
  assign misaligned = req_ok && !aligned;

  // A load finishes either in WAIT or in the very cycle ISSUE is accepted.
  assign load_done  = mem_done && !write_q &&
                      (((state == ISSUE) && !mem_stall) || (state == WAIT));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_err_q;

  assign timeout_hit = (state == WAIT) && !mem_done &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Counts WAIT cycles without mem_done; held at zero outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (!mem_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request-side outputs.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b1;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (halt) begin
          state_nxt = HALTED;
        end else if (req_valid) begin
          state_nxt = aligned ? ISSUE : HALTED;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_wr = write_q;
        if (!mem_stall) begin
          state_nxt = mem_done ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          state_nxt = HALTED;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = (halt_pend_q || halt) ? HALTED : IDLE;
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, load-data capture, deferred halt and sticky flags.
  // The dump pulse fires on the first cycle spent in HALTED, whatever the cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      write_q     <= 1'b0;
      rdata       <= '0;
      halt_pend_q <= 1'b0;
      align_err_q <= 1'b0;
      dump_q      <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        write_q   <= req_write;
      end
      if (load_done) begin
        rdata <= mem_rdata;
      end
      if (((state == ISSUE) || (state == WAIT)) && halt) begin
        halt_pend_q <= 1'b1;
      end
      if (misaligned) begin
        align_err_q <= 1'b1;
      end
      dump_q <= (state != HALTED) && (state_nxt == HALTED);
    end
  end

  assign align_err  = align_err_q;
  assign createdump = dump_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl. Expected load data is pushed to a
// scoreboard queue when a request is driven and popped whenever the DUT
// raises resp_valid. Honours MEM_TIMEOUT_EN the same way the RTL does.
module tb_mem_stage_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              halt = 1'b0;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] rdata;
  logic              align_err;
  logic              timeout_err;
  logic              createdump;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_stall = 1'b0;
  logic              mem_done = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  int stall_cnt, resp_cnt, dump_cnt, en_cnt;
  logic              s_stall, s_resp, s_dump, s_align, s_tout, s_mem_en, s_mem_wr;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [DATA_W-1:0] s_mem_wdata;
  int                stable_cnt;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .halt       (halt),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .align_err  (align_err),
    .timeout_err(timeout_err),
    .createdump (createdump),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata)
  );

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    stall_cnt  = 0;
    resp_cnt   = 0;
    dump_cnt   = 0;
    en_cnt     = 0;
    stable_cnt = 0;
  endtask

  // Drives one cycle of inputs, snapshots outputs mid-cycle, services the
  // scoreboard on resp_valid, then advances past the next rising edge.
  task automatic applyStimulus(input logic v, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic h, input logic ms,
                               input logic md, input logic [15:0] mr);
    logic [DATA_W-1:0] exp;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    halt      = h;
    mem_stall = ms;
    mem_done  = md;
    mem_rdata = mr;
    #1;
    s_stall     = stall;
    s_resp      = resp_valid;
    s_dump      = createdump;
    s_align     = align_err;
    s_tout      = timeout_err;
    s_mem_en    = mem_en;
    s_mem_wr    = mem_wr;
    s_mem_addr  = mem_addr;
    s_mem_wdata = mem_wdata;
    if (stall)      stall_cnt++;
    if (resp_valid) resp_cnt++;
    if (createdump) dump_cnt++;
    if (mem_en)     en_cnt++;
    if (resp_valid) begin
      checkOutput("resp_has_expectation", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checkOutput("rdata", 64'(rdata), 64'(exp));
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic doReset();
    req_valid = 1'b0;
    req_write = 1'b0;
    halt      = 1'b0;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    $display("[TB] start");
    clearCounts();

    // Reset values.
    #12;
    checkOutput("rst_stall", 64'(stall), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_mem_wr", 64'(mem_wr), 64'd0);
    checkOutput("rst_createdump", 64'(createdump), 64'd0);
    checkOutput("rst_align_err", 64'(align_err), 64'd0);
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #2;

    // Load 0x0010, data after two WAIT cycles.
    $display("[TB] load with two wait cycles");
    clearCounts();
    exp_q.push_back(16'hBEEF);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("load_accept_stall", 64'(s_stall), 64'd1);
    idleCycle();
    checkOutput("load_issue_en", 64'(s_mem_en), 64'd1);
    checkOutput("load_issue_wr", 64'(s_mem_wr), 64'd0);
    checkOutput("load_issue_addr", 64'(s_mem_addr), 64'h0010);
    idleCycle();
    checkOutput("load_wait_en", 64'(s_mem_en), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    idleCycle();
    checkOutput("load_resp", 64'(s_resp), 64'd1);
    idleCycle();
    checkOutput("load_idle_stall", 64'(s_stall), 64'd0);
    checkOutput("load_rdata_held", 64'(rdata), 64'hBEEF);
    checkOutput("load_stall_cycles", 64'(stall_cnt), 64'd5);
    checkOutput("load_resp_cycles", 64'(resp_cnt), 64'd1);

    // Store 0x0004 / 0x1234 with three memory stall cycles, done on acceptance.
    $display("[TB] store with memory stall");
    clearCounts();
    exp_q.push_back(16'hBEEF);
    applyStimulus(1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
      else       applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
      if (s_mem_en && s_mem_wr && s_mem_addr == 16'h0004 && s_mem_wdata == 16'h1234)
        stable_cnt++;
    end
    idleCycle();
    checkOutput("store_resp", 64'(s_resp), 64'd1);
    idleCycle();
    checkOutput("store_en_cycles", 64'(en_cnt), 64'd4);
    checkOutput("store_fields_stable", 64'(stable_cnt), 64'd4);
    checkOutput("store_resp_cycles", 64'(resp_cnt), 64'd1);

    // Reset during WAIT, late mem_done ignored, then a minimum-latency load.
    $display("[TB] reset during wait");
    clearCounts();
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idleCycle();
    idleCycle();
    rst = 1'b0;
    #1;
    checkOutput("midrst_stall", 64'(stall), 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_rdata", 64'(rdata), 64'd0);
    checkOutput("midrst_mem_en", 64'(mem_en), 64'd0);
    #2;
    rst = 1'b1;
    clearCounts();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h5555);
    idleCycle();
    checkOutput("late_done_no_resp", 64'(resp_cnt), 64'd0);
    clearCounts();
    exp_q.push_back(16'h0A5A);
    applyStimulus(1'b1, 1'b0, 16'h0022, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0A5A);
    idleCycle();
    idleCycle();
    checkOutput("minlat_stall_cycles", 64'(stall_cnt), 64'd3);
    checkOutput("minlat_resp_cycles", 64'(resp_cnt), 64'd1);

    // Halt during WAIT is deferred until after RESP.
    $display("[TB] halt during wait");
    clearCounts();
    exp_q.push_back(16'h7777);
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777);
    idleCycle();
    checkOutput("halt_resp_first", 64'(s_resp), 64'd1);
    checkOutput("halt_no_dump_in_resp", 64'(s_dump), 64'd0);
    idleCycle();
    checkOutput("halt_dump_after_resp", 64'(s_dump), 64'd1);
    checkOutput("halted_stall", 64'(s_stall), 64'd1);
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("halted_dump_once", 64'(s_dump), 64'd0);
    idleCycle();
    checkOutput("halted_no_issue", 64'(s_mem_en), 64'd0);
    checkOutput("halt_dump_count", 64'(dump_cnt), 64'd1);

    // Halt and request in the same IDLE cycle: request dropped.
    $display("[TB] halt with request");
    doReset();
    clearCounts();
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("halt_req_no_stall", 64'(s_stall), 64'd0);
    idleCycle();
    checkOutput("halt_req_dump", 64'(s_dump), 64'd1);
    idleCycle();
    idleCycle();
    checkOutput("halt_req_no_en", 64'(en_cnt), 64'd0);
    checkOutput("halt_req_no_resp", 64'(resp_cnt), 64'd0);

    // Misaligned load 0x0003.
    $display("[TB] misaligned load");
    doReset();
    clearCounts();
    applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idleCycle();
    checkOutput("misalign_err", 64'(s_align), 64'd1);
    checkOutput("misalign_dump", 64'(s_dump), 64'd1);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("misalign_stall_held", 64'(s_stall), 64'd1);
    checkOutput("misalign_err_sticky", 64'(s_align), 64'd1);
    checkOutput("misalign_dump_count", 64'(dump_cnt), 64'd1);
    checkOutput("misalign_no_en", 64'(en_cnt), 64'd0);

    // Memory never answers.
    $display("[TB] memory timeout");
    doReset();
    clearCounts();
    applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idleCycle();
    for (int i = 0; i < TIMEOUT; i++) idleCycle();
    checkOutput("tout_not_early", 64'(s_tout), 64'd0);
`ifdef MEM_TIMEOUT_EN
    idleCycle();
    checkOutput("tout_err", 64'(s_tout), 64'd1);
    checkOutput("tout_dump", 64'(s_dump), 64'd1);
    checkOutput("tout_stall", 64'(s_stall), 64'd1);
`else
    idleCycle();
    idleCycle();
    checkOutput("tout_disabled_err", 64'(s_tout), 64'd0);
    checkOutput("tout_disabled_waiting", 64'(s_stall), 64'd1);
    checkOutput("tout_disabled_no_dump", 64'(dump_cnt), 64'd0);
    exp_q.push_back(16'h1111);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1111);
    idleCycle();
    idleCycle();
    checkOutput("tout_disabled_resp", 64'(resp_cnt), 64'd1);
`endif
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits (power of two, 16..64).
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles waited for mem_done (used only when MEM_TIMEOUT_EN is defined).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  pipeline presents a load/store.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  ADDR_W  byte address (ALU result).
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 halt  in  1  pipeline halt request.
REQ-012 stall  out  1  freeze upstream stages.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 rdata  out  DATA_W  load data, valid with resp_valid.
REQ-015 align_err  out  1  sticky misaligned-access flag.
REQ-016 timeout_err  out  1  sticky memory-timeout flag.
REQ-017 createdump  out  1  one-cycle memory dump pulse.
REQ-018 mem_en, mem_wr  out  1  memory request strobe and write select.
REQ-019 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W.
REQ-020 mem_stall  in  1  memory cannot accept the request this cycle.
REQ-021 mem_done  in  1  access complete; mem_rdata valid.
REQ-022 mem_rdata  in  DATA_W  memory read data.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP, HALTED.
REQ-024 IDLE: req_valid & ~halt & aligned -> ISSUE, latching addr, wdata and write select.
REQ-025 Aligned means addr[log2(DATA_W/8)-1:0] == 0; a misaligned request sets align_err, issues no memory access, pulses createdump next cycle, then -> HALTED.
REQ-026 ISSUE: mem_en=1 with latched fields; mem_stall=1 -> remain in ISSUE (retry); else -> WAIT.
REQ-027 WAIT: mem_done=1 -> RESP, capturing mem_rdata; mem_done in the same cycle as the ISSUE acceptance is honoured, going straight to RESP.
REQ-028 RESP: resp_valid=1 for exactly one cycle, rdata holds the captured value until the next load completes; -> IDLE.
REQ-029 stall = 1 whenever state is not IDLE, and in IDLE on the cycle a request is accepted; minimum load/store latency is 3 cycles (accept, ISSUE, RESP).
REQ-030 halt in IDLE: createdump pulses one cycle, then -> HALTED; halt during ISSUE/WAIT/RESP is deferred until the operation completes.
REQ-031 HALTED: absorbing state; mem_en=0, stall=1, no further createdump.
REQ-032 halt and req_valid in the same IDLE cycle: halt wins and the request is dropped.

Reset
REQ-033 On rst low: state=IDLE; stall, resp_valid, mem_en, mem_wr, createdump, align_err, timeout_err = 0; rdata, mem_addr, mem_wdata = 0.
REQ-034 Reset asserted mid-operation aborts immediately with no resp_valid; mem_done arriving after reset is ignored.

Configuration
REQ-035 MEM_TIMEOUT_EN defined: a counter runs in WAIT; TIMEOUT cycles without mem_done sets timeout_err, pulses createdump and -> HALTED.
REQ-036 MEM_TIMEOUT_EN undefined: no counter is built, timeout_err is tied to 0, and WAIT waits indefinitely.

Structure
REQ-037 Package mem_stage_pkg holds the FSM state enum and a log2 helper for the offset width.
REQ-038 Sub-module mem_align_chk (combinational, parametrised by DATA_W/ADDR_W) produces the aligned flag.

Verification
REQ-039 Load addr 0x0010, memory returns 0xBEEF after 2 WAIT cycles -> resp_valid is one cycle, rdata = 0xBEEF, and stall is high for 5 cycles.
REQ-040 Store addr 0x0004 data 0x1234 with mem_stall high for 3 cycles -> mem_en is held 4 cycles in ISSUE, and mem_wr=1, mem_addr=0x0004, mem_wdata=0x1234 are stable throughout.
REQ-041 Load addr 0x0003 (DATA_W=16) -> no mem_en, align_err=1, a single createdump pulse, and stall stays high.
REQ-042 halt asserted during WAIT -> resp_valid fires first, createdump follows one cycle after RESP, then the block is HALTED.
REQ-043 With MEM_TIMEOUT_EN and TIMEOUT=8, mem_done is never returned -> timeout_err=1 after 8 WAIT cycles; without the macro the block stays in WAIT and timeout_err=0.
REQ-044 rst pulsed low during WAIT -> all outputs go to 0 immediately, a later mem_done produces no resp_valid, and the next request completes normally.
